// File: rtl/btn_step_conditioner.sv
// Push-button / direction-switch conditioner: 2-flop sync, CE-paced debounce, one STEP per press.
// Hold-to-repeat is built in when BTN_STEP_AUTOREPEAT_EN is defined.
module btn_step_conditioner #(
  parameter int DB_TICKS   = 20,
  parameter int REP_DELAY  = 500000,
  parameter int REP_PERIOD = 100000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic SYS_NRST,
  input  logic CE,
  input  logic btn,
  input  logic switch,
  output logic STEP,
  output logic UP
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_e;

  localparam int TICK_MAX =
    (DB_TICKS > REP_DELAY) ? ((DB_TICKS > REP_PERIOD) ? DB_TICKS : REP_PERIOD)
                           : ((REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD);
  localparam logic [CNT_W-1:0] TICK_MAX_C = CNT_W'(TICK_MAX);
  localparam logic [CNT_W-1:0] DB_C       = CNT_W'(DB_TICKS);

  // Counters stop at the largest tick target so they can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v < TICK_MAX_C) ? (v + CNT_W'(1)) : v;
  endfunction

  logic [1:0]       btn_sync_q;
  logic [1:0]       sw_sync_q;
  logic             btn_s;
  logic             sw_s;
  logic [CNT_W-1:0] sw_cnt_q;
  logic [CNT_W-1:0] sw_cnt_inc_s;
  logic             up_q;
  state_e           state_q;
  logic [CNT_W-1:0] btn_cnt_q;
  logic [CNT_W-1:0] btn_cnt_inc_s;
  logic             btn_release_s;
  logic             step_q;

  assign btn_s         = btn_sync_q[1];
  assign sw_s          = sw_sync_q[1];
  assign sw_cnt_inc_s  = sat_inc(sw_cnt_q);
  assign btn_cnt_inc_s = sat_inc(btn_cnt_q);
  assign btn_release_s = !btn_s && (btn_cnt_inc_s >= DB_C);

`ifdef BTN_STEP_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_C  = CNT_W'(REP_DELAY);
  localparam logic [CNT_W-1:0] REP_PERIOD_C = CNT_W'(REP_PERIOD);

  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] hold_inc_s;
  logic             rep_run_q;
  logic [CNT_W-1:0] rep_lim_s;

  assign hold_inc_s = sat_inc(hold_q);
  assign rep_lim_s  = rep_run_q ? REP_PERIOD_C : REP_DELAY_C;
`endif

  // Two-flop synchronisers; the switch path resets to "count up".
  always_ff @(posedge clk or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      btn_sync_q <= 2'b00;
      sw_sync_q  <= 2'b11;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn};
      sw_sync_q  <= {sw_sync_q[0], switch};
    end
  end

  // Direction debouncer: UP follows the synced switch after DB_TICKS differing ticks.
  always_ff @(posedge clk or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      sw_cnt_q <= '0;
      up_q     <= 1'b1;
    end else if (CE) begin
      if (sw_s != up_q) begin
        if (sw_cnt_inc_s >= DB_C) begin
          up_q     <= sw_s;
          sw_cnt_q <= '0;
        end else begin
          sw_cnt_q <= sw_cnt_inc_s;
        end
      end else begin
        sw_cnt_q <= '0;
      end
    end else begin
      sw_cnt_q <= sw_cnt_q;
    end
  end

  // Press/release FSM; btn_cnt_q debounces the press in IDLE and the release in PRESSED.
  always_ff @(posedge clk or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q   <= ST_IDLE;
      btn_cnt_q <= '0;
      step_q    <= 1'b0;
`ifdef BTN_STEP_AUTOREPEAT_EN
      hold_q    <= '0;
      rep_run_q <= 1'b0;
`endif
    end else if (CE) begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!btn_s) begin
            btn_cnt_q <= '0;
          end else if (btn_cnt_inc_s >= DB_C) begin
            state_q   <= ST_PRESSED;
            btn_cnt_q <= '0;
            step_q    <= 1'b1;
`ifdef BTN_STEP_AUTOREPEAT_EN
            hold_q    <= '0;
            rep_run_q <= 1'b0;
`endif
          end else begin
            btn_cnt_q <= btn_cnt_inc_s;
          end
        end
        ST_PRESSED: begin
          if (btn_s) begin
            btn_cnt_q <= '0;
          end else if (btn_release_s) begin
            state_q   <= ST_IDLE;
            btn_cnt_q <= '0;
`ifdef BTN_STEP_AUTOREPEAT_EN
            hold_q    <= '0;
            rep_run_q <= 1'b0;
`endif
          end else begin
            btn_cnt_q <= btn_cnt_inc_s;
          end
`ifdef BTN_STEP_AUTOREPEAT_EN
          // Hold time keeps running through short low glitches; a release tick never repeats.
          if (!btn_release_s) begin
            if (hold_inc_s >= rep_lim_s) begin
              hold_q    <= '0;
              rep_run_q <= 1'b1;
              step_q    <= !step_q;
            end else begin
              hold_q <= hold_inc_s;
            end
          end
`endif
        end
        default: begin
          state_q   <= ST_IDLE;
          btn_cnt_q <= '0;
        end
      endcase
    end else begin
      step_q <= 1'b0;
    end
  end

  assign STEP = step_q;
  assign UP   = up_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// Scoreboard bench for btn_step_conditioner: a window-based reference model queues expected
// STEP/UP events per clk edge and a negedge monitor pops and compares them.
module tb_btn_step_conditioner;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef BTN_STEP_AUTOREPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic SYS_NRST;
  logic CE;
  logic btn;
  logic switch;
  logic STEP;
  logic UP;

  btn_step_conditioner #(.DB_TICKS(DB), .REP_DELAY(RD), .REP_PERIOD(RP), .CNT_W(8)) dut (
    .clk(clk), .SYS_NRST(SYS_NRST), .CE(CE), .btn(btn), .switch(switch), .STEP(STEP), .UP(UP)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int  cyc;
  bit  b1, b2, s1, s2;
  bit  pressed, up_m;
  int  held;
  bit  bwin[$];
  bit  swin[$];
  int  exp_step[$];
  int  exp_up_c[$];
  int  exp_up_v[$];

  function automatic bit tail_all(input bit q[$], input bit v);
    if (q.size() < DB) return 1'b0;
    for (int i = q.size() - DB; i < q.size(); i++)
      if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      cyc = 0; b1 = 1'b0; b2 = 1'b0; s1 = 1'b1; s2 = 1'b1;
      pressed = 1'b0; up_m = 1'b1; held = 0;
      bwin.delete(); swin.delete();
      exp_step.delete(); exp_up_c.delete(); exp_up_v.delete();
    end else begin
      bit sb, ss;
      cyc++;
      sb = b2; ss = s2;
      b2 = b1; b1 = btn;
      s2 = s1; s1 = switch;
      if (CE) begin
        swin.push_back(ss);
        if (swin.size() > DB) void'(swin.pop_front());
        if (tail_all(swin, !up_m)) begin
          up_m = !up_m;
          exp_up_c.push_back(cyc);
          exp_up_v.push_back(int'(up_m));
          swin.delete();
        end
        bwin.push_back(sb);
        if (bwin.size() > DB) void'(bwin.pop_front());
        if (!pressed) begin
          if (tail_all(bwin, 1'b1)) begin
            pressed = 1'b1; held = 0; bwin.delete();
            exp_step.push_back(cyc);
          end
        end else begin
          held++;
          if (tail_all(bwin, 1'b0)) begin
            pressed = 1'b0; bwin.delete();
          end else if (REP && held >= RD && ((held - RD) % RP) == 0) begin
            exp_step.push_back(cyc);
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit up_last = 1'b1;
  bit prev_step = 1'b0;
  int step_seen = 0;
  int step_mark = 0;
  int first_step_cyc = -1;
  int up_changes = 0;
  int last_up_cyc = -1;

  always @(negedge clk) begin
    if (!SYS_NRST) begin
      up_last = 1'b1;
      prev_step = 1'b0;
    end else begin
      if (STEP) begin
        chk("step_gap", int'(prev_step), 0);
        if (exp_step.size() > 0) chk("step_cycle", cyc, exp_step.pop_front());
        else chk("step_unexpected", 1, 0);
        if (step_seen == step_mark) first_step_cyc = cyc;
        step_seen++;
      end else if (exp_step.size() > 0 && exp_step[0] <= cyc) begin
        chk("step_missing", 0, 1);
        void'(exp_step.pop_front());
      end
      prev_step = STEP;
      if (UP !== up_last) begin
        if (exp_up_c.size() > 0) begin
          chk("up_cycle", cyc, exp_up_c.pop_front());
          chk("up_value", int'(UP), exp_up_v.pop_front());
        end else begin
          chk("up_unexpected", 1, 0);
        end
        up_changes++;
        last_up_cyc = cyc;
        up_last = UP;
      end else if (exp_up_c.size() > 0 && exp_up_c[0] <= cyc) begin
        chk("up_missing", int'(UP), exp_up_v[0]);
        void'(exp_up_c.pop_front());
        void'(exp_up_v.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n, input logic b, input logic s, input bit rnd_ce, output int start);
    start = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) start = cyc + 1;
      btn = b;
      switch = s;
      CE = rnd_ce ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  endtask

  task automatic mark();
    step_mark = step_seen;
    first_step_cyc = -1;
  endtask

  initial begin
    int r, d, uc;
    logic rb, rs;
    SYS_NRST = 1'b0; CE = 1'b1; btn = 1'b0; switch = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_step", int'(STEP), 0);
    chk("reset_up", int'(UP), 1);
    #1 SYS_NRST = 1'b1;
    run(8, 1'b0, 1'b1, 1'b0, d);

    // Clean press held 20 clk.
    mark();
    run(20, 1'b1, 1'b1, 1'b0, r);
    run(12, 1'b0, 1'b1, 1'b0, d);
    chk("press_latency", first_step_cyc, r + 5);
`ifndef BTN_STEP_AUTOREPEAT_EN
    chk("press_once", step_seen - step_mark, 1);
`endif

    // Bounce 1-0-1-0 then stable high.
    mark();
    run(1, 1'b1, 1'b1, 1'b0, d);
    run(1, 1'b0, 1'b1, 1'b0, d);
    run(1, 1'b1, 1'b1, 1'b0, d);
    run(1, 1'b0, 1'b1, 1'b0, d);
    run(20, 1'b1, 1'b1, 1'b0, r);
    run(12, 1'b0, 1'b1, 1'b0, d);
    chk("bounce_latency", first_step_cyc, r + 5);
`ifndef BTN_STEP_AUTOREPEAT_EN
    chk("bounce_once", step_seen - step_mark, 1);
`endif

    // Held press with a 2-clk low glitch, release, second press.
    mark();
    run(12, 1'b1, 1'b1, 1'b0, d);
    run(2, 1'b0, 1'b1, 1'b0, d);
    run(8, 1'b1, 1'b1, 1'b0, d);
    run(10, 1'b0, 1'b1, 1'b0, d);
    run(10, 1'b1, 1'b1, 1'b0, d);
    run(12, 1'b0, 1'b1, 1'b0, d);
`ifndef BTN_STEP_AUTOREPEAT_EN
    chk("glitch_two_presses", step_seen - step_mark, 2);
`endif

    // Switch 1->0, back to 1, then a 3-clk low glitch.
    run(10, 1'b0, 1'b0, 1'b0, r);
    chk("up_fall_latency", last_up_cyc, r + 5);
    chk("up_low", int'(UP), 0);
    run(10, 1'b0, 1'b1, 1'b0, d);
    chk("up_high_again", int'(UP), 1);
    uc = up_changes;
    run(3, 1'b0, 1'b0, 1'b0, d);
    run(10, 1'b0, 1'b1, 1'b0, d);
    chk("up_glitch_ignored", up_changes - uc, 0);
    chk("up_still_high", int'(UP), 1);

    // Reset in the middle of a press debounce.
    mark();
    run(5, 1'b1, 1'b1, 1'b0, d);
    @(negedge clk);
    #1 SYS_NRST = 1'b0;
    #2;
    chk("midrst_step", int'(STEP), 0);
    chk("midrst_up", int'(UP), 1);
    repeat (2) @(negedge clk);
    #1 SYS_NRST = 1'b1;
    run(20, 1'b1, 1'b1, 1'b0, d);
    run(12, 1'b0, 1'b1, 1'b0, d);
    chk("post_reset_latency", first_step_cyc, 6);

    // Long hold: repeat build yields accept, +10, +15, +20, +25.
    mark();
    run(30, 1'b1, 1'b1, 1'b0, r);
    run(14, 1'b0, 1'b1, 1'b0, d);
    chk("hold_latency", first_step_cyc, r + 5);
`ifdef BTN_STEP_AUTOREPEAT_EN
    chk("hold_repeat_count", step_seen - step_mark, 5);
`else
    chk("hold_single", step_seen - step_mark, 1);
`endif

    // Random runs with an irregular CE.
    rs = 1'b1;
    for (int k = 0; k < 60; k++) begin
      rb = 1'(($urandom % 2));
      if ($urandom_range(0, 3) == 0) rs = !rs;
      run($urandom_range(1, 14), rb, rs, 1'b1, d);
    end
    run(30, 1'b0, rs, 1'b0, d);
    chk("step_queue_drained", exp_step.size(), 0);
    chk("up_queue_drained", exp_up_c.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
